// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI byte receiver: FSM encodings, counter width,
// synchronizer idle levels and bit-ordering helpers.
package spi_link_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned CNT_W = 3;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic CS_N_IDLE = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

   function automatic logic [7:0] shift_in(input logic [7:0] sr,
                                           input logic       din,
                                           input bit         msb_first);
      logic [7:0] res;
      if (msb_first) begin
         res = {sr[6:0], din};
      end else begin
         res = {din, sr[7:1]};
      end
      return res;
   endfunction

   // Bit of a transmit byte presented when idx bits of the byte have gone out.
   function automatic logic tx_pick(input logic [7:0]       data,
                                    input logic [CNT_W-1:0] idx,
                                    input bit               msb_first);
      logic res;
      if (msb_first) begin
         res = data[3'd7 - idx];
      end else begin
         res = data[idx];
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input, with a configurable
// depth and a reset value matching the input's idle level.
module sync_ff #(
   parameter int unsigned DEPTH   = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= {DEPTH{RST_VAL}};
      end else begin
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver sampled in the clk domain; optional MISO response
// path is built only when SPI_TX_EN is defined.
module spi_byte_rx
   import spi_link_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          MSB_FIRST   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_byte,
   output logic [7:0] out_byte,
   output logic       byte_finished,
   output logic       frame_abort,
   output logic       busy
);

   logic sck_s;
   logic cs_n_s;
   logic mosi_s;
   logic sck_prev;
   logic sck_rise;

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sync_sck (
      .clk   (clk),
      .reset (reset),
      .d     (spi_sck),
      .q     (sck_s)
   );

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs_n (
      .clk   (clk),
      .reset (reset),
      .d     (spi_cs_n),
      .q     (cs_n_s)
   );

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .d     (spi_mosi),
      .q     (mosi_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_prev <= SCK_IDLE;
      end else begin
         sck_prev <= sck_s;
      end
   end

   assign sck_rise = sck_s & ~sck_prev;

   state_t state;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (!cs_n_s) state_next = SHIFT;
         SHIFT:   if (cs_n_s)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   logic             enter;
   logic             leave;
   logic             active;
   logic             shift_edge;
   logic             complete;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       shreg;
   logic [7:0]       shreg_next;

   // An edge coinciding with CS deassert is dropped because active requires cs low.
   always_comb begin
      busy       = (state == SHIFT);
      enter      = (state == IDLE) && !cs_n_s;
      leave      = (state == SHIFT) && cs_n_s;
      active     = (state == SHIFT) && !cs_n_s && en;
      shift_edge = active && sck_rise;
      complete   = shift_edge && (bit_cnt == '1);
   end

   assign shreg_next = shift_in(shreg, mosi_s, MSB_FIRST);

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt       <= '0;
         shreg         <= '0;
         out_byte      <= '0;
         byte_finished <= 1'b0;
         frame_abort   <= 1'b0;
      end else begin
         frame_abort <= leave && (bit_cnt != '0);
         if (enter || leave) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (shift_edge) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg_next;
            if (complete) begin
               out_byte      <= shreg_next;
               byte_finished <= ~byte_finished;
            end
         end
      end
   end

`ifdef SPI_TX_EN
   logic       sck_fall;
   logic       shift_out;
   logic [7:0] tx_reg;

   assign sck_fall  = ~sck_s & sck_prev;
   assign shift_out = active && sck_fall;

   // MISO shows the bit indexed by bit_cnt, so the reload at byte completion
   // is picked up by the following falling edge when bit_cnt has wrapped to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_reg   <= '0;
         spi_miso <= 1'b0;
      end else if (enter) begin
         tx_reg   <= tx_byte;
         spi_miso <= tx_pick(tx_byte, '0, MSB_FIRST);
      end else begin
         if (complete) begin
            tx_reg <= tx_byte;
         end
         if (shift_out) begin
            spi_miso <= tx_pick(tx_reg, bit_cnt, MSB_FIRST);
         end
      end
   end
`else
   logic unused_tx;

   assign unused_tx = ^tx_byte;
   assign spi_miso  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Randomized bench for spi_byte_rx with a byte-level reference model.
module tb_spi_byte_rx;

   localparam int unsigned SYNC_STAGES = 2;
   localparam bit          MSB_FIRST   = 1'b1;
   localparam int          HALF        = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       spi_sck = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [7:0] tx_byte = 8'h00;
   logic [7:0] out_byte;
   logic       byte_finished;
   logic       frame_abort;
   logic       busy;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(MSB_FIRST)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .spi_sck       (spi_sck),
      .spi_cs_n      (spi_cs_n),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .tx_byte       (tx_byte),
      .out_byte      (out_byte),
      .byte_finished (byte_finished),
      .frame_abort   (frame_abort),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Observed activity, counted independently of the model.
   int   seen_toggles = 0;
   int   seen_aborts  = 0;
   logic bf_prev      = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         bf_prev      = 1'b0;
         seen_toggles = 0;
         seen_aborts  = 0;
      end else begin
         if (byte_finished !== bf_prev) begin
            seen_toggles++;
            bf_prev = byte_finished;
         end
         if (frame_abort === 1'b1) seen_aborts++;
      end
   end

   // Reference model: bits gathered per frame, byte value built arithmetically.
   int         m_cnt    = 0;
   int         m_acc    = 0;
   logic [7:0] exp_out  = 8'h00;
   int         exp_tog  = 0;
   int         exp_abrt = 0;
   logic [7:0] cur_tx   = 8'h00;

   function automatic logic tx_bit(input logic [7:0] data, input int idx);
      int sh;
      sh = MSB_FIRST ? (7 - idx) : idx;
      return ((data >> sh) & 8'd1) != 8'd0;
   endfunction

   task automatic drive_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      bit done;
      bit hit;
      spi_mosi = b;
      drive_wait(HALF);
`ifdef SPI_TX_EN
      check("miso", spi_miso, tx_bit(cur_tx, m_cnt));
`else
      check("miso_tied", spi_miso, 1'b0);
`endif
      spi_sck = 1'b1;
      done = 1'b0;
      if (en) begin
         if (MSB_FIRST) m_acc = (m_acc * 2) + int'(b);
         else           m_acc = m_acc + (int'(b) << m_cnt);
         m_cnt++;
         if (m_cnt == 8) begin
            exp_out = 8'(m_acc);
            exp_tog++;
            m_cnt = 0;
            m_acc = 0;
            done  = 1'b1;
         end
      end
      if (done) begin
         hit = 1'b0;
         for (int n = 0; n < int'(SYNC_STAGES) + 2 && !hit; n++) begin
            @(negedge clk);
            if (byte_finished === exp_tog[0]) hit = 1'b1;
         end
         check("toggle_latency", hit, 1'b1);
         check("out_byte_on_done", out_byte, exp_out);
      end
      drive_wait(HALF);
      spi_sck = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] value, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(MSB_FIRST ? value[7-i] : value[i]);
      end
   endtask

   task automatic cs_low();
      @(posedge clk); #2;
      spi_cs_n = 1'b0;
      m_cnt = 0;
      m_acc = 0;
      drive_wait(HALF);
      check("busy_in_frame", busy, 1'b1);
   endtask

   task automatic frame_checks();
      check("toggles", seen_toggles, exp_tog);
      check("aborts", seen_aborts, exp_abrt);
      check("out_byte", out_byte, exp_out);
      check("byte_finished", byte_finished, exp_tog[0]);
      check("busy_idle", busy, 1'b0);
   endtask

   task automatic count_abort(input bit expect_pulse);
      int hi;
      hi = 0;
      repeat (int'(SYNC_STAGES) + 4) begin
         @(negedge clk);
         if (frame_abort === 1'b1) hi++;
      end
      check("abort_width", hi, expect_pulse ? 1 : 0);
   endtask

   task automatic cs_high();
      bit ab;
      drive_wait(HALF);
      spi_cs_n = 1'b1;
      ab = (m_cnt != 0);
      if (ab) exp_abrt++;
      m_cnt = 0;
      m_acc = 0;
      count_abort(ab);
      frame_checks();
   endtask

   // Final SCK rise and CS deassert land on the same sample: edge must be lost.
   task automatic cs_high_on_edge(input logic b);
      bit ab;
      spi_mosi = b;
      drive_wait(HALF);
      spi_sck  = 1'b1;
      spi_cs_n = 1'b1;
      ab = (m_cnt != 0);
      if (ab) exp_abrt++;
      m_cnt = 0;
      m_acc = 0;
      count_abort(ab);
      drive_wait(HALF);
      spi_sck = 1'b0;
      drive_wait(HALF);
      frame_checks();
   endtask

   task automatic set_en(input logic v);
      drive_wait(HALF);
      en = v;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset    = 1'b1;
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      drive_wait(3);
      reset = 1'b0;
      m_cnt = 0; m_acc = 0; exp_out = 8'h00; exp_tog = 0; exp_abrt = 0;
      @(negedge clk);
      check("rst_out_byte", out_byte, 8'h00);
      check("rst_byte_finished", byte_finished, 1'b0);
      check("rst_frame_abort", frame_abort, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_miso", spi_miso, 1'b0);
      count_abort(1'b0);
      frame_checks();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // 0xA5 with response 0xC3
      cur_tx = 8'hC3; tx_byte = cur_tx;
      cs_low();
      send_bits(8'hA5, 8);
      cs_high();

      // multi-byte frame from a fresh reset
      do_reset();
      cs_low();
      send_bits(8'h40, 8);
      send_bits(8'h12, 8);
      send_bits(8'h34, 8);
      send_bits(8'h95, 8);
      cs_high();
      check("four_byte_final_level", byte_finished, 1'b0);

      // abort after 5 bits, then recovery
      cs_low();
      send_bits(8'h5A, 5);
      cs_high();
      cs_low();
      send_bits(8'h3C, 8);
      cs_high();

      // reset in the middle of a byte
      cs_low();
      send_bits(8'hF0, 3);
      do_reset();
      cs_low();
      send_bits(8'hFF, 8);
      cs_high();

      // en low for a full byte
      cs_low();
      set_en(1'b0);
      send_bits(8'h11, 8);
      set_en(1'b1);
      send_bits(8'h22, 8);
      cs_high();

      // CS deassert on the edge that would complete a byte
      cs_low();
      send_bits(8'h81, 7);
      cs_high_on_edge(1'b1);

      for (int f = 0; f < 24; f++) begin
         int nb;
         int part;
         cur_tx  = 8'($urandom);
         tx_byte = cur_tx;
         cs_low();
         nb = $urandom_range(1, 3);
         for (int k = 0; k < nb; k++) begin
            logic new_en;
            new_en = ($urandom_range(0, 3) != 0);
            if (new_en != en) set_en(new_en);
            send_bits(8'($urandom), 8);
         end
         part = $urandom_range(0, 7);
         send_bits(8'($urandom), part);
         if ($urandom_range(0, 7) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 1) == 0) begin
            cs_high_on_edge(1'($urandom));
         end else begin
            cs_high();
         end
         if (en != 1'b1) set_en(1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI input (range 2..4).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in bit 7, 0 = first bit lands in bit 0.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  receive enable; low = ignore SCK edges and hold all outputs.
REQ-006 SHALL have port spi_sck  input  1  asynchronous SPI clock, mode 0 (idle low, sample on rising edge).
REQ-007 SHALL have port spi_cs_n  input  1  asynchronous chip select, active low.
REQ-008 SHALL have port spi_mosi  input  1  asynchronous serial data in.
REQ-009 SHALL have port spi_miso  output  1  serial data out, registered.
REQ-010 SHALL have port tx_byte  input  8  response byte for the MISO path.
REQ-011 SHALL have port out_byte  output  8  last complete received byte.
REQ-012 SHALL have port byte_finished  output  1  level that toggles once per completed byte.
REQ-013 SHALL have port frame_abort  output  1  one-clk pulse when CS rises mid-byte.
REQ-014 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-015 SHALL pass spi_sck, spi_cs_n and spi_mosi each through SYNC_STAGES flops before use; edge detection uses the last two synchronized sck samples.
REQ-016 SHALL implement a two-state FSM: IDLE (synced cs_n high) -> SHIFT on synced cs_n low; SHIFT -> IDLE on synced cs_n high.
REQ-017 SHALL clear the 3-bit bit counter and the shift register on entry to SHIFT.
REQ-018 SHALL, in SHIFT with en high, shift synced mosi into the shift register on each detected sck rising edge and increment the bit counter; the counter wraps 7 -> 0.
REQ-019 SHALL, on the rising edge that completes bit 8, update out_byte with the full byte (including that bit) and invert byte_finished on the same clk; latency from the raw SCK edge is at most SYNC_STAGES+2 clk.
REQ-020 SHALL leave out_byte and byte_finished unchanged at every other time; byte_finished never toggles twice for one byte.
REQ-021 SHALL, on SHIFT -> IDLE with bit counter nonzero, discard the partial byte, pulse frame_abort high for exactly one clk and not toggle byte_finished; with counter zero, frame_abort stays low.
REQ-022 SHALL ignore sck edges while en is low; a byte in progress resumes when en returns high; en does not affect the FSM or CS handling.
REQ-023 SHALL treat simultaneous sck rising edge and cs_n deassert (same synced sample) as CS deassert: the edge is ignored.
REQ-024 SHALL require clk frequency >= 8x SCK frequency; behaviour below that is undefined.

Reset
REQ-025 SHALL, on reset, set out_byte=8'h00, byte_finished=0, frame_abort=0, busy=0, spi_miso=0, bit counter=0, shift register=0, FSM=IDLE.
REQ-026 SHALL preset the synchronizer chains on reset to idle levels (sck 0, cs_n 1, mosi 0) so no edge is detected in the first cycle after reset.
REQ-027 SHALL, if reset is asserted mid-byte, abandon the byte without frame_abort or byte_finished activity.

Configuration
REQ-028 SHALL, with SPI_TX_EN defined, latch tx_byte on SHIFT entry and on each byte completion, and drive spi_miso with its bits in MSB_FIRST order, first bit valid on SHIFT entry, next bit updated on each detected sck falling edge.
REQ-029 SHALL, without SPI_TX_EN, tie spi_miso to 0, ignore tx_byte and omit the transmit shift register.

Structure
REQ-030 SHALL take the FSM state encodings (IDLE, SHIFT), the bit-counter width (3) and the synchronizer idle levels from shared package spi_link_pkg.
REQ-031 SHALL instantiate a sub-module sync_ff (parameterized depth, reset value) once per SPI input.

Verification
REQ-032 CS low, shift 0xA5 MSB-first -> out_byte=0xA5, byte_finished 0->1 within SYNC_STAGES+2 clk of the 8th SCK rise, frame_abort stays 0.
REQ-033 One CS frame with 0x40,0x12,0x34,0x95 -> four toggles, out_byte sequence as sent, final byte_finished=0.
REQ-034 CS rises after 5 bits -> one-clk frame_abort pulse, no toggle, out_byte unchanged; next frame 0x3C -> out_byte=0x3C.
REQ-035 reset after 3 bits of 0xF0, then new frame 0xFF -> all outputs 0 after reset, then out_byte=0xFF with a single toggle.
REQ-036 en=0 for a whole 0x11 byte -> no toggle, out_byte held; en=1 for 0x22 -> out_byte=0x22.
REQ-037 With SPI_TX_EN, tx_byte=0xC3 before CS -> MISO sampled at SCK rises = 1,1,0,0,0,0,1,1; without the macro MISO=0 throughout.
